// File: rtl/fir_kernel_5x5_if.sv
// Pixel/coefficient bus for fir_kernel_5x5.
// master: upstream/host side (drives column pixels, syncs, coefficient writes).
// slave : the convolution kernel (drives filtered pixel, delayed syncs, commit status).
//   p0..p4        column pixels, p0 = oldest (top) row
//   dv_i/hs_i/vs_i sync strobes aligned with p0..p4
//   coef_we/addr/data  shadow coefficient write port
//   coef_commit   arm a shadow->active copy at the next vs rising edge
//   y_o, dv_o, hs_o, vs_o, commit_pend_o  kernel outputs
interface fir_kernel_5x5_if;
  logic [7:0] p0;
  logic [7:0] p1;
  logic [7:0] p2;
  logic [7:0] p3;
  logic [7:0] p4;
  logic       dv_i;
  logic       hs_i;
  logic       vs_i;
  logic       coef_we;
  logic [4:0] coef_addr;
  logic [7:0] coef_data;
  logic       coef_commit;
  logic [7:0] y_o;
  logic       dv_o;
  logic       hs_o;
  logic       vs_o;
  logic       commit_pend_o;

  modport master (
    output p0, p1, p2, p3, p4, dv_i, hs_i, vs_i,
    output coef_we, coef_addr, coef_data, coef_commit,
    input  y_o, dv_o, hs_o, vs_o, commit_pend_o
  );

  modport slave (
    input  p0, p1, p2, p3, p4, dv_i, hs_i, vs_i,
    input  coef_we, coef_addr, coef_data, coef_commit,
    output y_o, dv_o, hs_o, vs_o, commit_pend_o
  );
endinterface

// File: rtl/fir_kernel_5x5.sv
// 5x5 convolution kernel: builds a sliding window from the incoming pixel
// column, multiplies by a double-buffered signed coefficient set, normalises,
// clamps to 8 bits and emits one luma pixel per clock with syncs delayed to match.
// Ports: clk, rst (synchronous, active-high), bus (fir_kernel_5x5_if.slave).
module fir_kernel_5x5 #(
  parameter int unsigned SHIFT = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  fir_kernel_5x5_if.slave       bus
);

  localparam int unsigned LATENCY = 7;
  localparam int unsigned TAPS    = 5;
  localparam int unsigned NCOEF   = TAPS * TAPS;
  localparam int unsigned CENTRE  = NCOEF / 2;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned COEF_W  = 8;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned PROD_W  = PIX_W + 1 + COEF_W;
  localparam int unsigned ROW_W   = PROD_W + 3;
  localparam int unsigned SUM_W   = ROW_W + 2;
  localparam int unsigned CTL_W   = 3;
  localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(1 << SHIFT);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  logic        [PIX_W-1:0]  pcol_c   [TAPS];
  logic        [PIX_W-1:0]  win_q    [TAPS][TAPS];
  logic        [PIX_W-1:0]  win_d    [TAPS][TAPS];
  logic signed [PROD_W-1:0] prod_q   [TAPS][TAPS];
  logic signed [PROD_W-1:0] prod_d   [TAPS][TAPS];
  logic signed [ROW_W-1:0]  row_q    [TAPS];
  logic signed [ROW_W-1:0]  row_d    [TAPS];
  logic signed [SUM_W-1:0]  sum_q;
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  shifted_c;
  logic        [PIX_W-1:0]  y_q;
  logic        [PIX_W-1:0]  y_d;
  logic        [CTL_W-1:0]  ctl_q    [LATENCY];
  logic        [CTL_W-1:0]  ctl_d    [LATENCY];
  logic signed [COEF_W-1:0] shadow_q [NCOEF];
  logic signed [COEF_W-1:0] shadow_d [NCOEF];
  logic signed [COEF_W-1:0] active_q [NCOEF];
  logic signed [COEF_W-1:0] active_d [NCOEF];
  state_e                   state_q;
  state_e                   state_d;
  logic                     vs_prev_q;
  logic                     vs_prev_d;
  logic                     commit_pend_q;
  logic                     commit_pend_d;
  logic                     load_bank_c;

  // Incoming column as an array, row 0 on top.
  always_comb begin
    pcol_c[0] = bus.p0;
    pcol_c[1] = bus.p1;
    pcol_c[2] = bus.p2;
    pcol_c[3] = bus.p3;
    pcol_c[4] = bus.p4;
  end

  // S1..S4: window shift, products, row sums, total.
  always_comb begin
    for (int r = 0; r < TAPS; r++) begin
      win_d[r][0] = pcol_c[r];
      for (int c = 1; c < TAPS; c++) begin
        win_d[r][c] = win_q[r][c-1];
      end
    end
    for (int r = 0; r < TAPS; r++) begin
      for (int c = 0; c < TAPS; c++) begin
        // Pixel zero-extended to 9 bits so the signed multiply treats it as unsigned.
        prod_d[r][c] = PROD_W'($signed({1'b0, win_q[r][c]})) *
                       PROD_W'(active_q[r*TAPS + c]);
      end
    end
    for (int r = 0; r < TAPS; r++) begin
      row_d[r] = '0;
      for (int c = 0; c < TAPS; c++) begin
        row_d[r] = row_d[r] + ROW_W'(prod_q[r][c]);
      end
    end
    sum_d = '0;
    for (int r = 0; r < TAPS; r++) begin
      sum_d = sum_d + SUM_W'(row_q[r]);
    end
  end

  // S5: normalise, clamp, blank when the aligned dv is low.
  always_comb begin
    shifted_c = sum_q >>> SHIFT;
    ctl_d[0]  = {bus.dv_i, bus.hs_i, bus.vs_i};
    for (int i = 1; i < LATENCY; i++) begin
      ctl_d[i] = ctl_q[i-1];
    end
    if (!ctl_q[LATENCY-2][2]) begin
      y_d = '0;
    end else if (shifted_c[SUM_W-1]) begin
      y_d = '0;
    end else if (|shifted_c[SUM_W-2:PIX_W]) begin
      y_d = '1;
    end else begin
      y_d = shifted_c[PIX_W-1:0];
    end
  end

  // Commit FSM: arm on request, swap banks on the next vs rising edge.
  always_comb begin
    state_d     = state_q;
    load_bank_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.coef_commit) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (bus.vs_i && !vs_prev_q) begin
          state_d     = IDLE;
          load_bank_c = 1'b1;
        end
      end
    endcase
    vs_prev_d     = bus.vs_i;
    commit_pend_d = (state_d == ARMED);
  end

  // Coefficient banks; the copy reads shadow_q so a same-cycle write is not seen.
  always_comb begin
    for (int i = 0; i < NCOEF; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = load_bank_c ? shadow_q[i] : active_q[i];
    end
    if (bus.coef_we && (bus.coef_addr < ADDR_W'(NCOEF))) begin
      shadow_d[bus.coef_addr] = bus.coef_data;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < TAPS; r++) begin
        for (int c = 0; c < TAPS; c++) begin
          win_q[r][c]  <= '0;
          prod_q[r][c] <= '0;
        end
        row_q[r] <= '0;
      end
      for (int i = 0; i < LATENCY; i++) begin
        ctl_q[i] <= '0;
      end
      for (int i = 0; i < NCOEF; i++) begin
        shadow_q[i] <= (i == CENTRE) ? COEF_ONE : '0;
        active_q[i] <= (i == CENTRE) ? COEF_ONE : '0;
      end
      sum_q         <= '0;
      y_q           <= '0;
      state_q       <= IDLE;
      vs_prev_q     <= 1'b0;
      commit_pend_q <= 1'b0;
    end else begin
      win_q         <= win_d;
      prod_q        <= prod_d;
      row_q         <= row_d;
      ctl_q         <= ctl_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      sum_q         <= sum_d;
      y_q           <= y_d;
      state_q       <= state_d;
      vs_prev_q     <= vs_prev_d;
      commit_pend_q <= commit_pend_d;
    end
  end

  assign bus.y_o           = y_q;
  assign bus.dv_o          = ctl_q[LATENCY-1][2];
  assign bus.hs_o          = ctl_q[LATENCY-1][1];
  assign bus.vs_o          = ctl_q[LATENCY-1][0];
  assign bus.commit_pend_o = commit_pend_q;

endmodule
